// File: rtl/nmi_arbiter.sv
// Two-master round-robin arbiter in front of a single native-memory-interface slave.
// Define NMI_ARB_TIMEOUT_EN to abort hung slave accesses with an ERR_DATA response.
module nmi_arbiter #(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    WSTRB_WIDTH    = (DATA_WIDTH - 1) / 8 + 1,
   parameter int                    TIMEOUT_CYCLES = 255,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   m0_mem_valid,
   input  logic                   m0_mem_instr,
   input  logic [ADDR_WIDTH-1:0]  m0_mem_addr,
   input  logic [DATA_WIDTH-1:0]  m0_mem_wdata,
   input  logic [WSTRB_WIDTH-1:0] m0_mem_wstrb,
   output logic                   m0_mem_ready,
   output logic [DATA_WIDTH-1:0]  m0_mem_rdata,
   input  logic                   m1_mem_valid,
   input  logic                   m1_mem_instr,
   input  logic [ADDR_WIDTH-1:0]  m1_mem_addr,
   input  logic [DATA_WIDTH-1:0]  m1_mem_wdata,
   input  logic [WSTRB_WIDTH-1:0] m1_mem_wstrb,
   output logic                   m1_mem_ready,
   output logic [DATA_WIDTH-1:0]  m1_mem_rdata,
   output logic                   s_mem_valid,
   output logic                   s_mem_instr,
   output logic [ADDR_WIDTH-1:0]  s_mem_addr,
   output logic [DATA_WIDTH-1:0]  s_mem_wdata,
   output logic [WSTRB_WIDTH-1:0] s_mem_wstrb,
   input  logic                   s_mem_ready,
   input  logic [DATA_WIDTH-1:0]  s_mem_rdata,
   output logic                   arb_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ERR   = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   gnt_q, gnt_d;
   logic   last_q, last_d;
   logic   gnt_valid_s;

   assign gnt_valid_s = gnt_q ? m1_mem_valid : m0_mem_valid;

`ifdef NMI_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`else
   logic unused_cfg_s;
   assign unused_cfg_s = (^ERR_DATA) ^ (TIMEOUT_CYCLES > 0);
`endif

   // next-state: grant selection, completion, abandonment and timeout
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
`ifdef NMI_ARB_TIMEOUT_EN
      to_cnt_d = to_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (m0_mem_valid || m1_mem_valid) begin
               state_d = GRANT;
               // on a tie the master not served last wins
               gnt_d   = (m0_mem_valid && m1_mem_valid) ? ~last_q : m1_mem_valid;
`ifdef NMI_ARB_TIMEOUT_EN
               to_cnt_d = '0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (!gnt_valid_s) begin
               state_d = IDLE;
            end else if (s_mem_ready) begin
               state_d = IDLE;
               last_d  = gnt_q;
`ifdef NMI_ARB_TIMEOUT_EN
            end else if (to_cnt_q == TO_LAST) begin
               state_d = ERR;
            end else begin
               to_cnt_d = to_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
`else
            end else begin
               state_d = GRANT;
            end
`endif
         end
`ifdef NMI_ARB_TIMEOUT_EN
         ERR: begin
            state_d = IDLE;
            last_d  = gnt_q;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
`ifdef NMI_ARB_TIMEOUT_EN
         to_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
`ifdef NMI_ARB_TIMEOUT_EN
         to_cnt_q <= to_cnt_d;
`endif
      end
   end

   // output decode; reset forces every output low regardless of state
   always_comb begin
      s_mem_valid  = 1'b0;
      s_mem_instr  = 1'b0;
      s_mem_addr   = '0;
      s_mem_wdata  = '0;
      s_mem_wstrb  = '0;
      m0_mem_ready = 1'b0;
      m0_mem_rdata = '0;
      m1_mem_ready = 1'b0;
      m1_mem_rdata = '0;
      arb_err      = 1'b0;
      case (rst ? IDLE : state_q)
         GRANT: begin
            s_mem_valid = gnt_valid_s;
            s_mem_instr = gnt_q ? m1_mem_instr : m0_mem_instr;
            s_mem_addr  = gnt_q ? m1_mem_addr  : m0_mem_addr;
            s_mem_wdata = gnt_q ? m1_mem_wdata : m0_mem_wdata;
            s_mem_wstrb = gnt_q ? m1_mem_wstrb : m0_mem_wstrb;
            if (gnt_q) begin
               m1_mem_ready = s_mem_ready & gnt_valid_s;
               m1_mem_rdata = s_mem_rdata;
            end else begin
               m0_mem_ready = s_mem_ready & gnt_valid_s;
               m0_mem_rdata = s_mem_rdata;
            end
         end
`ifdef NMI_ARB_TIMEOUT_EN
         ERR: begin
            arb_err = 1'b1;
            if (gnt_q) begin
               m1_mem_ready = 1'b1;
               m1_mem_rdata = ERR_DATA;
            end else begin
               m0_mem_ready = 1'b1;
               m0_mem_rdata = ERR_DATA;
            end
         end
`endif
         default: begin
            arb_err = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_nmi_arbiter.sv
// Directed bench for nmi_arbiter: per-cycle comparison against a transaction-level
// model, plus hand-computed checks; honours NMI_ARB_TIMEOUT_EN like the design.
module tb_nmi_arbiter;

   localparam int TO = 4;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mv [2];
   logic        mi [2];
   logic [31:0] ma [2];
   logic [31:0] md [2];
   logic [3:0]  ms [2];
   logic        mr [2];
   logic [31:0] mq [2];
   logic        s_valid, s_instr, s_ready, arb_err;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   bit rec_on = 1'b0;
   int rec_who [$];
   int rec_cyc [$];

   // model: who is being served (-1 = nobody), error pending, last served, stall count
   int  m_who = -1;
   bit  m_err = 1'b0;
   int  m_last = 1;
   int  m_stall = 0;

   nmi_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WSTRB_WIDTH(4),
                 .TIMEOUT_CYCLES(TO), .ERR_DATA(ERRD)) dut (
      .clk(clk), .rst(rst),
      .m0_mem_valid(mv[0]), .m0_mem_instr(mi[0]), .m0_mem_addr(ma[0]),
      .m0_mem_wdata(md[0]), .m0_mem_wstrb(ms[0]), .m0_mem_ready(mr[0]), .m0_mem_rdata(mq[0]),
      .m1_mem_valid(mv[1]), .m1_mem_instr(mi[1]), .m1_mem_addr(ma[1]),
      .m1_mem_wdata(md[1]), .m1_mem_wstrb(ms[1]), .m1_mem_ready(mr[1]), .m1_mem_rdata(mq[1]),
      .s_mem_valid(s_valid), .s_mem_instr(s_instr), .s_mem_addr(s_addr),
      .s_mem_wdata(s_wdata), .s_mem_wstrb(s_wstrb),
      .s_mem_ready(s_ready), .s_mem_rdata(s_rdata), .arb_err(arb_err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // per-cycle compare against the model, then advance the model for the next edge
   always @(negedge clk) begin
      logic        e_sv, e_si, e_err;
      logic [31:0] e_sa, e_sw;
      logic [3:0]  e_ss;
      logic        e_r [2];
      logic [31:0] e_d [2];
      e_sv = 1'b0; e_si = 1'b0; e_err = 1'b0; e_sa = '0; e_sw = '0; e_ss = '0;
      e_r[0] = 1'b0; e_r[1] = 1'b0; e_d[0] = '0; e_d[1] = '0;
      if (!rst && m_who >= 0) begin
         if (m_err) begin
            e_r[m_who] = 1'b1;
            e_d[m_who] = ERRD;
            e_err = 1'b1;
         end else begin
            e_sv = mv[m_who]; e_si = mi[m_who]; e_sa = ma[m_who];
            e_sw = md[m_who]; e_ss = ms[m_who];
            e_r[m_who] = s_ready && mv[m_who];
            e_d[m_who] = s_rdata;
         end
      end
      chk("s_valid", {31'd0, s_valid}, {31'd0, e_sv});
      chk("s_instr", {31'd0, s_instr}, {31'd0, e_si});
      chk("s_addr", s_addr, e_sa);
      chk("s_wdata", s_wdata, e_sw);
      chk("s_wstrb", {28'd0, s_wstrb}, {28'd0, e_ss});
      chk("m0_ready", {31'd0, mr[0]}, {31'd0, e_r[0]});
      chk("m1_ready", {31'd0, mr[1]}, {31'd0, e_r[1]});
      chk("m0_rdata", mq[0], e_d[0]);
      chk("m1_rdata", mq[1], e_d[1]);
      chk("arb_err", {31'd0, arb_err}, {31'd0, e_err});
      if (rec_on && mr[0]) begin rec_who.push_back(0); rec_cyc.push_back(cyc); end
      if (rec_on && mr[1]) begin rec_who.push_back(1); rec_cyc.push_back(cyc); end
      if (rst) begin
         m_who = -1; m_err = 1'b0; m_last = 1; m_stall = 0;
      end else if (m_err) begin
         m_last = m_who; m_who = -1; m_err = 1'b0;
      end else if (m_who < 0) begin
         m_stall = 0;
         if (mv[0] && mv[1]) m_who = 1 - m_last;
         else if (mv[0]) m_who = 0;
         else if (mv[1]) m_who = 1;
      end else if (!mv[m_who]) begin
         m_who = -1;
      end else if (s_ready) begin
         m_last = m_who; m_who = -1;
`ifdef NMI_ARB_TIMEOUT_EN
      end else if (m_stall == TO - 1) begin
         m_err = 1'b1;
`endif
      end else begin
         m_stall++;
      end
   end

   initial begin
      int exp_order [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
      for (int i = 0; i < 2; i++) begin
         mv[i] = 1'b0; mi[i] = 1'b0; ma[i] = '0; md[i] = '0; ms[i] = '0;
      end
      s_ready = 1'b0; s_rdata = '0;
      step(); step();
      rst = 1'b0;

      // single read from master 0, slave always ready
      ma[0] = 32'h10; mv[0] = 1'b1; s_ready = 1'b1; s_rdata = 32'h1234_5678;
      #1 chk("rd_sv_idle", {31'd0, s_valid}, 32'd0);
      step();
      chk("rd_sv", {31'd0, s_valid}, 32'd1);
      chk("rd_ready", {31'd0, mr[0]}, 32'd1);
      chk("rd_rdata", mq[0], 32'h1234_5678);
      chk("rd_m1_ready", {31'd0, mr[1]}, 32'd0);
      step();
      mv[0] = 1'b0;
      #1 chk("rd_ready_pulse", {31'd0, mr[0]}, 32'd0);

      // contention from reset: strict alternation, one ready every second cycle
      rst = 1'b1; mv[0] = 1'b1; mv[1] = 1'b1; ma[0] = 32'h100; ma[1] = 32'h200;
      step();
      rst = 1'b0; rec_who.delete(); rec_cyc.delete(); rec_on = 1'b1;
      repeat (16) step();
      rec_on = 1'b0; mv[0] = 1'b0; mv[1] = 1'b0;
      chk("cont_count", rec_who.size(), 32'd8);
      for (int i = 0; i < 8 && i < rec_who.size(); i++) begin
         chk("cont_order", rec_who[i], exp_order[i]);
         if (i > 0) chk("cont_gap", rec_cyc[i] - rec_cyc[i-1], 32'd2);
      end

      // write passthrough from master 1
      ma[1] = 32'h20; md[1] = 32'hAABB_CCDD; ms[1] = 4'b0011; mi[1] = 1'b0; mv[1] = 1'b1;
      s_rdata = '0;
      step();
      chk("wr_addr", s_addr, 32'h20);
      chk("wr_wdata", s_wdata, 32'hAABB_CCDD);
      chk("wr_wstrb", {28'd0, s_wstrb}, 32'd3);
      chk("wr_m1_ready", {31'd0, mr[1]}, 32'd1);
      chk("wr_m0_ready", {31'd0, mr[0]}, 32'd0);
      step();
      mv[1] = 1'b0; ms[1] = '0;

      // slow slave: three stalled cycles then ready
      s_ready = 1'b0; ma[0] = 32'h30; mi[0] = 1'b1; mv[0] = 1'b1; s_rdata = 32'h0BAD_F00D;
      repeat (3) begin
         step();
         chk("slow_sv", {31'd0, s_valid}, 32'd1);
         chk("slow_addr", s_addr, 32'h30);
         chk("slow_instr", {31'd0, s_instr}, 32'd1);
         chk("slow_ready", {31'd0, mr[0]}, 32'd0);
         chk("slow_err", {31'd0, arb_err}, 32'd0);
      end
      s_ready = 1'b1;
      #1 chk("slow_ready_same", {31'd0, mr[0]}, 32'd1);
      chk("slow_rdata", mq[0], 32'h0BAD_F00D);
      step();
      mv[0] = 1'b0; mi[0] = 1'b0;

      // slave never ready
      s_ready = 1'b0; ma[0] = 32'h40; mv[0] = 1'b1;
      repeat (5) step();
`ifdef NMI_ARB_TIMEOUT_EN
      chk("to_ready", {31'd0, mr[0]}, 32'd1);
      chk("to_rdata", mq[0], ERRD);
      chk("to_err", {31'd0, arb_err}, 32'd1);
      chk("to_sv", {31'd0, s_valid}, 32'd0);
`else
      chk("stuck_sv", {31'd0, s_valid}, 32'd1);
      chk("stuck_ready", {31'd0, mr[0]}, 32'd0);
      chk("stuck_err", {31'd0, arb_err}, 32'd0);
`endif
      mv[0] = 1'b0;
      step();
      chk("to_err_pulse", {31'd0, arb_err}, 32'd0);
      mv[0] = 1'b1; mv[1] = 1'b1; ma[1] = 32'h50; s_ready = 1'b1;
      step();
      chk("to_tie_m1", {31'd0, mr[1]}, 32'd1);
      chk("to_tie_m0", {31'd0, mr[0]}, 32'd0);
      chk("to_tie_addr", s_addr, 32'h50);
      step();
      mv[0] = 1'b0; mv[1] = 1'b0;

      // reset mid-transfer after master 0 was served last
      mv[0] = 1'b1; ma[0] = 32'h70;
      step(); step();
      mv[0] = 1'b0; s_ready = 1'b0; ma[1] = 32'h60; mv[1] = 1'b1;
      step();
      chk("rst_pre_sv", {31'd0, s_valid}, 32'd1);
      rst = 1'b1;
      #1 chk("rst_sv_during", {31'd0, s_valid}, 32'd0);
      step();
      rst = 1'b0;
      chk("rst_sv_after", {31'd0, s_valid}, 32'd0);
      chk("rst_m1_after", {31'd0, mr[1]}, 32'd0);
      mv[0] = 1'b1; s_ready = 1'b1;
      step();
      chk("rst_tie_m0", {31'd0, mr[0]}, 32'd1);
      chk("rst_tie_m1", {31'd0, mr[1]}, 32'd0);
      chk("rst_tie_addr", s_addr, 32'h70);
      step();
      mv[0] = 1'b0; mv[1] = 1'b0;
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
